// File: rtl/prtcl_chkr_mmio_rd_tracker_pkg.sv
// Shared types and constants for the protocol checker MMIO read tracker.
// Header layout matches what the response generator needs to build a dummy completion.
package prtcl_chkr_pkg;

  localparam int PCIE_TLP_TAG_WIDTH  = 8;
  localparam int SYNC_FIFO_DEPTH     = 16;
  localparam int MMIO_TIMEOUT_CYCLES = 512;

  typedef struct packed {
    logic [7:0]  tag;
    logic [9:0]  dw0_len;
    logic [15:0] requester_id;
    logic [31:0] addr;
  } t_mmio_timeout_hdr_info;

  localparam int MMIO_TIMEOUT_HDR_INFO_WIDTH = $bits(t_mmio_timeout_hdr_info);

  localparam int MMIO_TIMEOUT_ERR         = 0;
  localparam int UNEXP_MMIO_RSP_ERR       = 1;
  localparam int TAG_OCCUPIED_ERR         = 2;
  localparam int TX_REQ_COUNTER_OFLOW_ERR = 3;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_TIMING,
    TMR_TO_WAIT
  } t_mmio_tmr_state;

endpackage

// File: rtl/prtcl_chkr_mmio_rd_tracker_if.sv
// Request/completion/timeout-handshake/error bundle of the MMIO read tracker.
// master drives requests, completions and to_ready; slave is the tracker.
interface prtcl_chkr_mmio_rd_tracker_if;
  import prtcl_chkr_pkg::*;

  logic                   req_valid;
  t_mmio_timeout_hdr_info req_info;
  logic                   cpl_valid;
  logic [7:0]             cpl_tag;
  logic                   to_valid;
  logic                   to_ready;
  t_mmio_timeout_hdr_info to_hdr_info;
  logic                   err_mmio_timeout;
  logic                   err_unexp_mmio_rsp;
  logic                   err_tag_occupied;
  logic                   err_req_oflow;
  logic [4:0]             pending_cnt;

  modport master (
    output req_valid, req_info, cpl_valid, cpl_tag, to_ready,
    input  to_valid, to_hdr_info, err_mmio_timeout, err_unexp_mmio_rsp,
           err_tag_occupied, err_req_oflow, pending_cnt
  );

  modport slave (
    input  req_valid, req_info, cpl_valid, cpl_tag, to_ready,
    output to_valid, to_hdr_info, err_mmio_timeout, err_unexp_mmio_rsp,
           err_tag_occupied, err_req_oflow, pending_cnt
  );

endinterface

// File: rtl/prtcl_chkr_mmio_rd_tracker_tag_table.sv
// Per-tag pending bit plus the FIFO slot holding that tag; two clear ports, one set port.
// Same-cycle set beats clear so a tag retired and reissued in one cycle stays pending.
module prtcl_chkr_mmio_tag_table #(
  parameter  int NUM_TAGS = 256,
  parameter  int SLOT_W   = 4,
  localparam int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [TAG_W-1:0]  set_tag_i,
  input  logic [SLOT_W-1:0] set_slot_i,
  input  logic              clr_a_i,
  input  logic [TAG_W-1:0]  clr_a_tag_i,
  input  logic              clr_b_i,
  input  logic [TAG_W-1:0]  clr_b_tag_i,
  input  logic [TAG_W-1:0]  lkp_tag_i,
  output logic              lkp_pend_o,
  output logic [SLOT_W-1:0] lkp_slot_o,
  input  logic [TAG_W-1:0]  chk_tag_i,
  output logic              chk_pend_o
);

  logic [NUM_TAGS-1:0] pend_q, pend_d;
  logic [SLOT_W-1:0]   slot_q [NUM_TAGS];

  always_comb begin
    pend_d = pend_q;
    if (clr_a_i) pend_d[clr_a_tag_i] = 1'b0;
    if (clr_b_i) pend_d[clr_b_tag_i] = 1'b0;
    if (set_i)   pend_d[set_tag_i]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Slot is only meaningful while the pending bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (set_i) slot_q[set_tag_i] <= set_slot_i;
  end

  assign lkp_pend_o = pend_q[lkp_tag_i];
  assign lkp_slot_o = slot_q[lkp_tag_i];
  assign chk_pend_o = pend_q[chk_tag_i];

endmodule

// File: rtl/prtcl_chkr_mmio_rd_tracker.sv
// Tracks outstanding MMIO reads in an in-order ring, flags timeout/unexpected/tag-reuse errors.
// Errors are registered (1 cycle); a timeout holds to_valid/to_hdr_info until to_ready.
module prtcl_chkr_mmio_rd_tracker
  import prtcl_chkr_pkg::*;
#(
  parameter int DEPTH    = SYNC_FIFO_DEPTH,
  parameter int NUM_TAGS = 2**PCIE_TLP_TAG_WIDTH,
  parameter int TIMEOUT  = MMIO_TIMEOUT_CYCLES
) (
  input logic                         clk,
  input logic                         rst_n,
  prtcl_chkr_mmio_rd_tracker_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  t_mmio_timeout_hdr_info info_q [DEPTH];
  logic [DEPTH-1:0]       live_q, live_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  t_mmio_tmr_state        state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  t_mmio_timeout_hdr_info to_hdr_q;
  logic                   err_to_q, err_unexp_q, err_occ_q, err_oflow_q;

  logic             cpl_pend, req_pend, cpl_hit, req_busy;
  logic [PTR_W-1:0] cpl_slot;
  logic             full, empty, push, pop, oflow, occupied, unexp;
  logic             head_live, fire;

  prtcl_chkr_mmio_tag_table #(
    .NUM_TAGS (NUM_TAGS),
    .SLOT_W   (PTR_W)
  ) u_tag_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (push),
    .set_tag_i   (bus.req_info.tag),
    .set_slot_i  (wr_ptr_q),
    .clr_a_i     (cpl_hit),
    .clr_a_tag_i (bus.cpl_tag),
    .clr_b_i     (fire),
    .clr_b_tag_i (info_q[rd_ptr_q].tag),
    .lkp_tag_i   (bus.cpl_tag),
    .lkp_pend_o  (cpl_pend),
    .lkp_slot_o  (cpl_slot),
    .chk_tag_i   (bus.req_info.tag),
    .chk_pend_o  (req_pend)
  );

  // Completion is applied first: a tag freed this cycle may be reissued this cycle.
  assign cpl_hit  = bus.cpl_valid & cpl_pend;
  assign unexp    = bus.cpl_valid & ~cpl_pend;
  assign req_busy = req_pend & ~(cpl_hit & (bus.cpl_tag == bus.req_info.tag));
  assign full     = (occ_q == CNT_W'(DEPTH));
  assign empty    = (occ_q == '0);
  assign oflow    = bus.req_valid & full;
  assign occupied = bus.req_valid & ~full & req_busy;
  assign push     = bus.req_valid & ~full & ~req_busy;

  assign head_live = ~empty & live_q[rd_ptr_q] & ~(cpl_hit & (cpl_slot == rd_ptr_q));
  assign pop       = ~empty & (~head_live | fire);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    fire    = 1'b0;
    unique case (state_q)
      TMR_IDLE: begin
        if (head_live) begin
          state_d = TMR_TIMING;
          tmr_d   = TMR_W'(1);
        end
      end
      TMR_TIMING: begin
        if (!head_live) begin
          state_d = TMR_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          fire    = 1'b1;
          state_d = TMR_TO_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      TMR_TO_WAIT: begin
        if (bus.to_ready) state_d = TMR_IDLE;
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  always_comb begin
    live_d = live_q;
    if (cpl_hit) live_d[cpl_slot] = 1'b0;
    if (fire)    live_d[rd_ptr_q] = 1'b0;
    if (push)    live_d[wr_ptr_q] = 1'b1;
  end

  assign occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(cpl_hit) - CNT_W'(fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      state_q     <= TMR_IDLE;
      tmr_q       <= '0;
      to_hdr_q    <= '0;
      err_to_q    <= 1'b0;
      err_unexp_q <= 1'b0;
      err_occ_q   <= 1'b0;
      err_oflow_q <= 1'b0;
    end else begin
      live_q      <= live_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      if (fire) to_hdr_q <= info_q[rd_ptr_q];
      err_to_q    <= fire;
      err_unexp_q <= unexp;
      err_occ_q   <= occupied;
      err_oflow_q <= oflow;
    end
  end

  always_ff @(posedge clk) begin
    if (push) info_q[wr_ptr_q] <= bus.req_info;
  end

  assign bus.to_valid           = (state_q == TMR_TO_WAIT);
  assign bus.to_hdr_info        = to_hdr_q;
  assign bus.err_mmio_timeout   = err_to_q;
  assign bus.err_unexp_mmio_rsp = err_unexp_q;
  assign bus.err_tag_occupied   = err_occ_q;
  assign bus.err_req_oflow      = err_oflow_q;
  assign bus.pending_cnt        = cnt_q;

endmodule

// File: tb/tb_prtcl_chkr_mmio_rd_tracker.sv
// Directed bench for the MMIO read tracker; timeout headers are checked through a scoreboard.
module tb_prtcl_chkr_mmio_rd_tracker;
  import prtcl_chkr_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_to_p = 0, n_unexp_p = 0, n_occ_p = 0, n_ofl_p = 0, n_hs = 0;
  t_mmio_timeout_hdr_info exp_q [$];
  t_mmio_timeout_hdr_info h7, h2, h_exp;

  prtcl_chkr_mmio_rd_tracker_if b ();

  prtcl_chkr_mmio_rd_tracker #(
    .DEPTH    (16),
    .NUM_TAGS (256),
    .TIMEOUT  (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic t_mmio_timeout_hdr_info mk(input logic [7:0] tag);
    t_mmio_timeout_hdr_info h;
    h.tag          = tag;
    h.dw0_len      = 10'($urandom);
    h.requester_id = 16'($urandom);
    h.addr         = $urandom;
    return h;
  endfunction

  task automatic req(input t_mmio_timeout_hdr_info h);
    b.req_valid = 1'b1;
    b.req_info  = h;
    tick();
    b.req_valid = 1'b0;
  endtask

  task automatic cpl(input logic [7:0] t);
    b.cpl_valid = 1'b1;
    b.cpl_tag   = t;
    tick();
    b.cpl_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Pulse counters and the timeout-header scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (b.err_mmio_timeout)   n_to_p++;
    if (b.err_unexp_mmio_rsp) n_unexp_p++;
    if (b.err_tag_occupied)   n_occ_p++;
    if (b.err_req_oflow)      n_ofl_p++;
    if (rst_n && b.to_valid && b.to_ready) begin
      n_hs++;
      chk("to_hs_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        h_exp = exp_q.pop_front();
        chk("to_hdr_scoreboard", 128'(b.to_hdr_info), 128'(h_exp));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    b.req_valid = 1'b0;
    b.req_info  = '0;
    b.cpl_valid = 1'b0;
    b.cpl_tag   = '0;
    b.to_ready  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_to_valid", 128'(b.to_valid), 128'(0));
    chk("rst_to_hdr", 128'(b.to_hdr_info), 128'(0));
    chk("rst_pending_cnt", 128'(b.pending_cnt), 128'(0));
    chk("rst_errs", 128'({b.err_mmio_timeout, b.err_unexp_mmio_rsp,
                          b.err_tag_occupied, b.err_req_oflow}), 128'(0));

    // 1: simple request/completion
    req(mk(8'd5));
    chk("t1_cnt_after_req", 128'(b.pending_cnt), 128'(1));
    repeat (9) tick();
    cpl(8'd5);
    chk("t1_cnt_after_cpl", 128'(b.pending_cnt), 128'(0));
    chk("t1_unexp", 128'(b.err_unexp_mmio_rsp), 128'(0));
    chk("t1_to_valid", 128'(b.to_valid), 128'(0));

    // 2: timeout, held response handshake, late completion
    do_reset();
    b.to_ready = 1'b0;
    h7 = mk(8'd7);
    exp_q.push_back(h7);
    req(h7);
    repeat (63) tick();
    chk("t2_no_to_at_63", 128'(b.err_mmio_timeout), 128'(0));
    tick();
    chk("t2_to_at_64", 128'(b.err_mmio_timeout), 128'(1));
    chk("t2_to_valid", 128'(b.to_valid), 128'(1));
    chk("t2_to_hdr", 128'(b.to_hdr_info), 128'(h7));
    chk("t2_cnt", 128'(b.pending_cnt), 128'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 128'(b.to_valid), 128'(1));
      chk("t2_hold_hdr", 128'(b.to_hdr_info), 128'(h7));
    end
    b.to_ready = 1'b1;
    tick();
    chk("t2_valid_drop", 128'(b.to_valid), 128'(0));
    cpl(8'd7);
    chk("t2_late_cpl", 128'(b.err_unexp_mmio_rsp), 128'(1));

    // 3: overflow and tag reuse
    do_reset();
    for (int i = 0; i < 16; i++) req(mk(8'(i)));
    chk("t3_cnt_full", 128'(b.pending_cnt), 128'(16));
    req(mk(8'd20));
    chk("t3_oflow", 128'(b.err_req_oflow), 128'(1));
    chk("t3_cnt_oflow", 128'(b.pending_cnt), 128'(16));
    cpl(8'd0);
    chk("t3_cnt_after_cpl0", 128'(b.pending_cnt), 128'(15));
    req(mk(8'd3));
    chk("t3_occupied", 128'(b.err_tag_occupied), 128'(1));
    chk("t3_cnt_occupied", 128'(b.pending_cnt), 128'(15));
    cpl(8'd20);
    chk("t3_dropped_tag", 128'(b.err_unexp_mmio_rsp), 128'(1));

    // 4: out-of-order completions, then timer restart on head change
    do_reset();
    req(mk(8'd1));
    req(mk(8'd2));
    req(mk(8'd3));
    chk("t4_cnt3", 128'(b.pending_cnt), 128'(3));
    cpl(8'd3);
    cpl(8'd2);
    cpl(8'd1);
    chk("t4_cnt0", 128'(b.pending_cnt), 128'(0));
    repeat (3) tick();
    req(mk(8'd3));
    chk("t4_tag3_reusable", 128'(b.err_tag_occupied), 128'(0));
    do_reset();
    req(mk(8'd1));
    h2 = mk(8'd2);
    exp_q.push_back(h2);
    req(h2);
    repeat (29) tick();
    cpl(8'd1);
    repeat (63) tick();
    chk("t4_no_to_early", 128'(b.err_mmio_timeout), 128'(0));
    tick();
    chk("t4_to_restart", 128'(b.err_mmio_timeout), 128'(1));
    chk("t4_to_hdr", 128'(b.to_hdr_info), 128'(h2));
    tick();
    chk("t4_valid_drop", 128'(b.to_valid), 128'(0));

    // 5: same-cycle free and reissue; completion on expiry cycle
    do_reset();
    req(mk(8'd9));
    b.cpl_valid = 1'b1;
    b.cpl_tag   = 8'd9;
    b.req_valid = 1'b1;
    b.req_info  = mk(8'd9);
    tick();
    b.cpl_valid = 1'b0;
    b.req_valid = 1'b0;
    chk("t5_no_occupied", 128'(b.err_tag_occupied), 128'(0));
    chk("t5_no_unexp", 128'(b.err_unexp_mmio_rsp), 128'(0));
    chk("t5_cnt1", 128'(b.pending_cnt), 128'(1));
    cpl(8'd9);
    chk("t5_tag9_pending", 128'(b.err_unexp_mmio_rsp), 128'(0));
    chk("t5_cnt0", 128'(b.pending_cnt), 128'(0));
    do_reset();
    req(mk(8'd11));
    repeat (63) tick();
    cpl(8'd11);
    chk("t5_expiry_cpl_wins", 128'(b.err_mmio_timeout), 128'(0));
    chk("t5_expiry_no_unexp", 128'(b.err_unexp_mmio_rsp), 128'(0));
    chk("t5_expiry_cnt", 128'(b.pending_cnt), 128'(0));
    repeat (3) tick();
    chk("t5_expiry_no_valid", 128'(b.to_valid), 128'(0));

    // 6: reset while a timeout response is waiting
    do_reset();
    b.to_ready = 1'b0;
    req(mk(8'd4));
    req(mk(8'd6));
    repeat (63) tick();
    chk("t6_to_valid", 128'(b.to_valid), 128'(1));
    chk("t6_cnt_before", 128'(b.pending_cnt), 128'(1));
    tick();
    tick();
    do_reset();
    chk("t6_rst_valid", 128'(b.to_valid), 128'(0));
    chk("t6_rst_cnt", 128'(b.pending_cnt), 128'(0));
    chk("t6_rst_hdr", 128'(b.to_hdr_info), 128'(0));
    b.to_ready = 1'b1;
    cpl(8'd6);
    chk("t6_old_tag_unexp", 128'(b.err_unexp_mmio_rsp), 128'(1));
    repeat (3) tick();

    chk("tot_timeout_pulses", 128'(n_to_p), 128'(3));
    chk("tot_unexp_pulses", 128'(n_unexp_p), 128'(3));
    chk("tot_occupied_pulses", 128'(n_occ_p), 128'(1));
    chk("tot_oflow_pulses", 128'(n_ofl_p), 128'(1));
    chk("tot_handshakes", 128'(n_hs), 128'(2));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
